intr_pend_bank: RTL and testbench

- Parametrised multi-channel interrupt pending latch bank with mask and fixed-priority arbitration; succeeds the single set/reset interrupt flop.
- Each channel latches a request (edge- or level-sourced) until acknowledged.
- Presents one registered interrupt line plus channel ID to the Tramelblaze.
- Flags requests that arrive while the same channel is already pending (overflow).

---
 rtl/intr_pend_bank_pkg.sv | 21 ++
 rtl/intr_prio_enc.sv | 27 ++
 rtl/intr_pend_bank.sv | 141 ++++++++++++++
 tb/tb_intr_pend_bank.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pend_bank_pkg.sv
// intr_pend_bank_pkg
//   Shared definitions for the interrupt pending latch bank and the
//   Tramelblaze wrapper that instantiates it:
//     - INTR_NUM_CH_DFLT : default channel count
//     - arb_state_e      : arbitration FSM state encoding
//     - id_width()       : width of a channel index (clog2, minimum 1)
package intr_pend_bank_pkg;

  localparam int unsigned INTR_NUM_CH_DFLT = 8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } arb_state_e;

  // A single channel still needs a 1-bit ID so intr_id is never zero-width.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// intr_prio_enc
//   Combinational fixed-priority encoder, lowest index wins.
//   Ports:
//     req_i [NUM_CH-1:0] : request vector
//     idx_o [ID_W-1:0]   : index of the lowest set bit (0 when none set)
//     any_o              : 1 when any request bit is set
module intr_prio_enc #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned ID_W   = 3
) (
  input  logic [NUM_CH-1:0] req_i,
  output logic [ID_W-1:0]   idx_o,
  output logic              any_o
);

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (req_i[i] && !any_o) begin
        idx_o = ID_W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_pend_bank.sv
// intr_pend_bank
//   Multi-channel interrupt pending latch bank with enable mask, sticky
//   overflow flags and fixed-priority (lowest index first) arbitration.
//   One registered interrupt line plus channel ID goes to the processor.
//   Ports:
//     clk        : system clock, all state on the rising edge
//     reset      : asynchronous active-low reset
//     src        : raw per-channel requests (synchronous to clk)
//     mask_we    : load strobe for the mask register
//     mask_wdata : new mask value, 1 = channel enabled
//     mask       : current mask register
//     ack        : one-cycle acknowledge pulse from the processor
//     intr       : interrupt request to the processor
//     intr_id    : index of the presented channel, valid while intr = 1
//     pending    : per-channel pending latches
//     ovf_clr    : clears all overflow flags
//     overflow   : sticky per-channel overflow flags
module intr_pend_bank
  import intr_pend_bank_pkg::*;
#(
  parameter int unsigned NUM_CH    = INTR_NUM_CH_DFLT,
  parameter int unsigned EDGE_MODE = 1,
  parameter int unsigned ID_W      = id_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] src,
  input  logic              mask_we,
  input  logic [NUM_CH-1:0] mask_wdata,
  output logic [NUM_CH-1:0] mask,
  input  logic              ack,
  output logic              intr,
  output logic [ID_W-1:0]   intr_id,
  output logic [NUM_CH-1:0] pending,
  input  logic              ovf_clr,
  output logic [NUM_CH-1:0] overflow
);

  logic [NUM_CH-1:0] set_s;
  logic [NUM_CH-1:0] clr_s;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic              intr_q, intr_d;
  logic [ID_W-1:0]   id_q, id_d;
  arb_state_e        state_q, state_d;

  logic [ID_W-1:0]   enc_idx;
  logic              enc_any;

  // Set request source. src_q resets to 0, so a src held high across reset
  // release is seen as a rising edge.
  if (EDGE_MODE != 0) begin : g_edge
    logic [NUM_CH-1:0] src_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) src_q <= '0;
      else        src_q <= src;
    end

    assign set_s = src & ~src_q;
  end else begin : g_level
    assign set_s = src;
  end

  // Only an ack against a presented interrupt clears anything.
  always_comb begin
    clr_s = '0;
    if (ack && intr_q) clr_s[id_q] = 1'b1;
  end

  // Set wins over a simultaneous clear; a new overflow wins over ovf_clr.
  always_comb begin
    pending_d = set_s | (pending_q & ~clr_s);
    ovf_d     = (ovf_clr ? '0 : ovf_q) | (set_s & pending_q & ~clr_s);
    mask_d    = mask_we ? mask_wdata : mask_q;
  end

  // Arbitrates from registered pending/mask only.
  intr_prio_enc #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_prio_enc (
    .req_i (pending_q & mask_q),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  always_comb begin
    state_d = state_q;
    intr_d  = intr_q;
    id_d    = id_q;
    unique case (state_q)
      ST_IDLE: begin
        intr_d = 1'b0;
        if (enc_any) begin
          intr_d  = 1'b1;
          id_d    = enc_idx;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // ID held and intr kept even if the channel is masked meanwhile.
        intr_d = 1'b1;
        if (ack) begin
          intr_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        intr_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      ovf_q     <= '0;
      mask_q    <= '0;
      intr_q    <= 1'b0;
      id_q      <= '0;
      state_q   <= ST_IDLE;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      mask_q    <= mask_d;
      intr_q    <= intr_d;
      id_q      <= id_d;
      state_q   <= state_d;
    end
  end

  assign mask     = mask_q;
  assign intr     = intr_q;
  assign intr_id  = id_q;
  assign pending  = pending_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_intr_pend_bank.sv
module tb_intr_pend_bank;

  localparam int unsigned NCH = 8;
  localparam int unsigned IDW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] src;
  logic           mask_we;
  logic [NCH-1:0] mask_wdata;
  logic [NCH-1:0] mask;
  logic           ack;
  logic           intr;
  logic [IDW-1:0] intr_id;
  logic [NCH-1:0] pending;
  logic           ovf_clr;
  logic [NCH-1:0] overflow;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string          tag;
    logic [NCH-1:0] pend;
    logic           intr;
    logic [IDW-1:0] id;
    bit             chk_id;
    logic [NCH-1:0] ovf;
    logic [NCH-1:0] mask;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  intr_pend_bank #(
    .NUM_CH    (NCH),
    .EDGE_MODE (1),
    .ID_W      (IDW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .src        (src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask       (mask),
    .ack        (ack),
    .intr       (intr),
    .intr_id    (intr_id),
    .pending    (pending),
    .ovf_clr    (ovf_clr),
    .overflow   (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [NCH-1:0] p, input logic i,
                           input logic [IDW-1:0] id, input bit cid,
                           input logic [NCH-1:0] o, input logic [NCH-1:0] m);
    exp_t e;
    e.tag = tag; e.pend = p; e.intr = i; e.id = id; e.chk_id = cid; e.ovf = o; e.mask = m;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty got 0 entries required 1");
      return;
    end
    e = sb.pop_front();
    n_assert++;
    assert (pending === e.pend) else begin
      n_fail++;
      $error("FAIL %s.pending got %h required %h", e.tag, pending, e.pend);
    end
    n_assert++;
    assert (intr === e.intr) else begin
      n_fail++;
      $error("FAIL %s.intr got %b required %b", e.tag, intr, e.intr);
    end
    if (e.chk_id) begin
      n_assert++;
      assert (intr_id === e.id) else begin
        n_fail++;
        $error("FAIL %s.intr_id got %0d required %0d", e.tag, intr_id, e.id);
      end
    end
    n_assert++;
    assert (overflow === e.ovf) else begin
      n_fail++;
      $error("FAIL %s.overflow got %h required %h", e.tag, overflow, e.ovf);
    end
    n_assert++;
    assert (mask === e.mask) else begin
      n_fail++;
      $error("FAIL %s.mask got %h required %h", e.tag, mask, e.mask);
    end
  endtask

  initial begin
    reset = 1'b0; src = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; ovf_clr = 1'b0;
    #2;
    expect_st("reset", 8'h00, 1'b0, 3'd0, 1'b1, 8'h00, 8'h00); check();
    @(negedge clk); reset = 1'b1;

    // enable all channels
    mask_we = 1'b1; mask_wdata = 8'hFF;
    expect_st("mask_ff", 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF); step(); check();
    mask_we = 1'b0;

    // single channel: set -> present -> ack
    src = 8'h08;
    expect_st("c3_set", 8'h08, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF); step(); check();
    src = 8'h00;
    expect_st("c3_pres", 8'h08, 1'b1, 3'd3, 1'b1, 8'h00, 8'hFF); step(); check();
    ack = 1'b1;
    expect_st("c3_ack", 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF); step(); check();
    ack = 1'b0;

    // two channels together: lowest first, gap cycle, then the other
    src = 8'h24;
    expect_st("c25_set", 8'h24, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF); step(); check();
    src = 8'h00;
    expect_st("c2_pres", 8'h24, 1'b1, 3'd2, 1'b1, 8'h00, 8'hFF); step(); check();
    ack = 1'b1;
    expect_st("c2_ack", 8'h20, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF); step(); check();
    ack = 1'b0;
    expect_st("c5_pres", 8'h20, 1'b1, 3'd5, 1'b1, 8'h00, 8'hFF); step(); check();
    ack = 1'b1;
    expect_st("c5_ack", 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF); step(); check();
    ack = 1'b0;

    // masked request stays pending without intr until unmasked
    mask_we = 1'b1; mask_wdata = 8'h00;
    expect_st("mask_00", 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00); step(); check();
    mask_we = 1'b0; src = 8'h02;
    expect_st("c1_masked", 8'h02, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00); step(); check();
    src = 8'h00;
    expect_st("c1_hold", 8'h02, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00); step(); check();
    mask_we = 1'b1; mask_wdata = 8'h02;
    expect_st("mask_02", 8'h02, 1'b0, 3'd0, 1'b0, 8'h00, 8'h02); step(); check();
    mask_we = 1'b0;
    expect_st("c1_pres", 8'h02, 1'b1, 3'd1, 1'b1, 8'h00, 8'h02); step(); check();
    ack = 1'b1;
    expect_st("c1_ack", 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'h02); step(); check();
    ack = 1'b0; mask_we = 1'b1; mask_wdata = 8'hFF;
    expect_st("mask_ff2", 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF); step(); check();
    mask_we = 1'b0;

    // overflow, clear, set-beats-clear, ack coincident with re-set
    src = 8'h10;
    expect_st("c4_set", 8'h10, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF); step(); check();
    src = 8'h00;
    expect_st("c4_pres", 8'h10, 1'b1, 3'd4, 1'b1, 8'h00, 8'hFF); step(); check();
    src = 8'h10;
    expect_st("c4_ovf", 8'h10, 1'b1, 3'd4, 1'b1, 8'h10, 8'hFF); step(); check();
    src = 8'h00; ovf_clr = 1'b1;
    expect_st("ovf_clr", 8'h10, 1'b1, 3'd4, 1'b1, 8'h00, 8'hFF); step(); check();
    src = 8'h10;
    expect_st("ovf_wins", 8'h10, 1'b1, 3'd4, 1'b1, 8'h10, 8'hFF); step(); check();
    src = 8'h00;
    expect_st("ovf_clr2", 8'h10, 1'b1, 3'd4, 1'b1, 8'h00, 8'hFF); step(); check();
    ovf_clr = 1'b0; src = 8'h10; ack = 1'b1;
    expect_st("c4_ack_reset", 8'h10, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF); step(); check();
    src = 8'h00; ack = 1'b0;
    expect_st("c4_repres", 8'h10, 1'b1, 3'd4, 1'b1, 8'h00, 8'hFF); step(); check();
    ack = 1'b1;
    expect_st("c4_ack", 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF); step(); check();
    ack = 1'b0;

    // ack while idle is ignored (masked pending + overflow present)
    mask_we = 1'b1; mask_wdata = 8'h00;
    expect_st("mask_00b", 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00); step(); check();
    mask_we = 1'b0; src = 8'h01;
    expect_st("c0_set", 8'h01, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00); step(); check();
    src = 8'h00; step();
    src = 8'h01;
    expect_st("c0_ovf", 8'h01, 1'b0, 3'd0, 1'b0, 8'h01, 8'h00); step(); check();
    src = 8'h00; ack = 1'b1;
    expect_st("idle_ack", 8'h01, 1'b0, 3'd0, 1'b0, 8'h01, 8'h00); step(); check();
    ack = 1'b0;
    expect_st("idle_ack_after", 8'h01, 1'b0, 3'd0, 1'b0, 8'h01, 8'h00); step(); check();

    // drain channel 0, then build pending = 0C while presenting
    mask_we = 1'b1; mask_wdata = 8'h01;
    expect_st("mask_01", 8'h01, 1'b0, 3'd0, 1'b0, 8'h01, 8'h01); step(); check();
    mask_we = 1'b0;
    expect_st("c0_pres", 8'h01, 1'b1, 3'd0, 1'b1, 8'h01, 8'h01); step(); check();
    ack = 1'b1; ovf_clr = 1'b1;
    expect_st("c0_ack", 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'h01); step(); check();
    ack = 1'b0; ovf_clr = 1'b0; mask_we = 1'b1; mask_wdata = 8'hFF;
    step();
    mask_we = 1'b0; src = 8'h0C;
    expect_st("c23_set", 8'h0C, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF); step(); check();
    src = 8'h00;
    expect_st("c2_pres_b", 8'h0C, 1'b1, 3'd2, 1'b1, 8'h00, 8'hFF); step(); check();

    // asynchronous reset mid-present
    #2 reset = 1'b0;
    #1;
    expect_st("async_reset", 8'h00, 1'b0, 3'd0, 1'b1, 8'h00, 8'h00); check();
    src = 8'h01;
    @(negedge clk); reset = 1'b1;
    expect_st("rel_src_high", 8'h01, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00); step(); check();
    expect_st("rel_masked", 8'h01, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00); step(); check();
    src = 8'h00;

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain got %0d entries required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
